// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder sequencer.
// Imported by serial_adder_ctrl; optional overflow flag via SERIAL_ADD_OVF_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic in the serial adder.
// Purely combinational.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused WIDTH times, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder_ctrl: WIDTH must be in 2..32");
    end

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic step;
    logic last;

    full_adder_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        last   = 1'b0;
        if (state == IDLE || state == DONE) begin
            accept = start;
        end
        if (state == RUN) begin
            step = 1'b1;
            last = (cnt == LAST);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (step) begin
            cnt   <= cnt + CW'(1);
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_co;
            sum   <= {fa_s, sum[WIDTH-1:1]};
            if (last) cout <= fa_co;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last step the carry flop holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= carry ^ fa_co;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2 instances).
// Expected results are queued at stimulus time and popped on each done pulse.
module tb_serial_adder_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp8_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8;
    logic       ovf2;
`endif

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;

    int n_checks = 0;
    int n_errors = 0;

    exp8_t      q8[$];
    logic [2:0] q2[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y,
                                     input logic c);
        exp8_t    e;
        logic [8:0] t;
        t      = {1'b0, x} + {1'b0, y} + {8'd0, c};
        e.sum  = t[7:0];
        e.cout = t[8];
        e.ovf  = (x[7] == y[7]) && (t[7] != x[7]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("done8_spurious", 1, 0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                check("sum8", {24'd0, sum8}, {24'd0, e.sum});
                check("cout8", {31'd0, cout8}, {31'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
                check("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                check("done2_spurious", 1, 0);
            end else begin
                logic [2:0] e;
                e = q2.pop_front();
                check("sum2", {29'd0, cout2, sum2}, {29'd0, e});
            end
        end
    end

    task automatic wait_done8();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("timeout8", 0, 1);
    endtask

    // Returns posedges after the accept edge until done and busy cycles seen.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic c, output int edges, output int bcnt);
        bit seen;
        @(posedge clk);
        #1;
        a8 = x;
        b8 = y;
        cin8 = c;
        start8 = 1'b1;
        q8.push_back(model8(x, y, c));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        edges = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                break;
            end
            if (busy8) bcnt++;
            @(posedge clk);
            edges++;
        end
        if (!seen) check("timeout8", 0, 1);
    endtask

    task automatic run2(input logic [1:0] x, input logic [1:0] y,
                        input logic c);
        bit seen;
        logic [2:0] t;
        @(posedge clk);
        #1;
        a2 = x;
        b2 = y;
        cin2 = c;
        start2 = 1'b1;
        t = {1'b0, x} + {1'b0, y} + {2'd0, c};
        q2.push_back(t);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("timeout2", 0, 1);
    endtask

    initial begin
        int edges;
        int bcnt;
        exp8_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_done", {31'd0, done8}, 0);
        check("rst_sum", {24'd0, sum8}, 0);
        check("rst_cout", {31'd0, cout8}, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", {31'd0, ovf8}, 0);
`endif
        rst = 1'b0;

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    run2(2'(x), 2'(y), 1'(c));

        run8(8'h0F, 8'h01, 1'b0, edges, bcnt);
        check("latency", edges, 8);
        check("busy_cycles", bcnt, 8);
        run8(8'hFF, 8'h01, 1'b0, edges, bcnt);
        run8(8'h7F, 8'h01, 1'b0, edges, bcnt);
        run8(8'h80, 8'h80, 1'b0, edges, bcnt);
        run8(8'hFF, 8'hFF, 1'b1, edges, bcnt);
        check("busy_cycles_ff", bcnt, 8);
        for (int i = 0; i < 8; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), edges, bcnt);
        end

        // Start held through RUN with new operands: only the DONE cycle takes them.
        @(posedge clk);
        #1;
        a8 = 8'h12;
        b8 = 8'h34;
        cin8 = 1'b1;
        start8 = 1'b1;
        q8.push_back(model8(8'h12, 8'h34, 1'b1));
        @(posedge clk);
        #1;
        a8 = 8'hA5;
        b8 = 8'h5A;
        cin8 = 1'b0;
        q8.push_back(model8(8'hA5, 8'h5A, 1'b0));
        wait_done8();
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'd0, busy8}, 1);
        wait_done8();

        // Abort mid-run: partial sum is nonzero before reset hits.
        @(posedge clk);
        #1;
        a8 = 8'hFF;
        b8 = 8'h00;
        cin8 = 1'b0;
        start8 = 1'b1;
        e = model8(8'hFF, 8'h00, 1'b0);
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("partial_sum", {24'd0, sum8}, 32'hE0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q8.delete();
        @(negedge clk);
        check("abort_busy", {31'd0, busy8}, 0);
        check("abort_done", {31'd0, done8}, 0);
        check("abort_sum", {24'd0, sum8}, 0);
        check("abort_cout", {31'd0, cout8}, 0);
        repeat (15) @(posedge clk);

        run8(8'h01, 8'h02, 1'b0, edges, bcnt);
        repeat (3) @(posedge clk);
        check("queue_empty", q8.size() + q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
